// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared op codes, FSM encoding and default widths for ex_muldiv
package ex_muldiv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int TAG_W_DEFAULT = 5;

  // RV32M funct3 encodings
  localparam logic [2:0] MULDIV_MUL_OP    = 3'b000;
  localparam logic [2:0] MULDIV_MULH_OP   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU_OP = 3'b010;
  localparam logic [2:0] MULDIV_MULHU_OP  = 3'b011;
  localparam logic [2:0] MULDIV_DIV_OP    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU_OP   = 3'b101;
  localparam logic [2:0] MULDIV_REM_OP    = 3'b110;
  localparam logic [2:0] MULDIV_REMU_OP   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - issue/result handshake bundle between ID/EX, ex_muldiv and EX/MEM
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
);

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  src1_i;
  logic [XLEN-1:0]  src2_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  // pipeline side: issues operations and consumes results
  modport master (
    output flush_i, in_valid_i, op_i, src1_i, src2_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );

  // the multiply/divide unit itself
  modport slave (
    input  flush_i, in_valid_i, op_i, src1_i, src2_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add or restoring-subtract step (divider only with EX_MULDIV_DIV_EN)
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;

  // multiply: {hi, lo} with the multiplier in lo; add the multiplicand to hi when lo[0] is set, then shift right keeping the carry
  always_comb begin
    mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    mul_acc = {mul_sum, acc_i[XLEN-1:1]};
  end

`ifdef EX_MULDIV_DIV_EN
  logic [XLEN:0]     div_top;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_acc;

  // divide: {rem, quo} shifted left one; the partial remainder needs XLEN+1 bits before the trial subtract
  always_comb begin
    div_top  = acc_i[2*XLEN-1:XLEN-1];
    div_diff = div_top - {1'b0, opnd_i};
    if (!div_diff[XLEN]) begin
      div_acc = {div_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      div_acc = {div_top[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

  assign acc_o = is_div ? div_acc : mul_acc;
`else
  // without a divider the accumulator simply holds for divide ops (they never reach CALC)
  assign acc_o = is_div ? acc_i : mul_acc;
`endif

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit; divider built only when EX_MULDIV_DIV_EN is defined
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              alive_q;

  logic [2:0]        in_op;
  logic              in_is_div;
  logic              src1_signed, src2_signed;
  logic              neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   calc_res;

  assign in_op     = bus.op_i;
  assign in_is_div = in_op[2];

  // decode signedness, operand magnitudes and the result sign of the presented operation
  always_comb begin
    src1_signed = (in_op == MULDIV_MULH_OP) || (in_op == MULDIV_MULHSU_OP) ||
                  (in_op == MULDIV_DIV_OP)  || (in_op == MULDIV_REM_OP);
    src2_signed = (in_op == MULDIV_MULH_OP) || (in_op == MULDIV_DIV_OP) ||
                  (in_op == MULDIV_REM_OP);
    neg1 = src1_signed && bus.src1_i[XLEN-1];
    neg2 = src2_signed && bus.src2_i[XLEN-1];
    mag1 = neg1 ? -bus.src1_i : bus.src1_i;
    mag2 = neg2 ? -bus.src2_i : bus.src2_i;
  end

`ifdef EX_MULDIV_DIV_EN
  logic div_zero, div_ovf;

  // divide by zero and MIN/-1 bypass the iteration with fixed results
  always_comb begin
    div_zero    = in_is_div && (bus.src2_i == '0);
    div_ovf     = in_is_div && !in_op[0] && (bus.src1_i == MOST_NEG) && (bus.src2_i == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = in_op[1] ? bus.src1_i : '1;
    end else if (div_ovf) begin
      special_res = in_op[1] ? '0 : MOST_NEG;
    end
  end
`else
  // every divide op completes at once with a zero result when no divider is built
  always_comb begin
    special     = in_is_div;
    special_res = '0;
  end
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // sign fix-up and half selection applied to the accumulator after the last step
  always_comb begin
    prod     = neg_q ? -step_acc : step_acc;
    calc_res = (op_q == MULDIV_MUL_OP) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef EX_MULDIV_DIV_EN
    if (op_q[2]) begin
      if (op_q[1]) begin
        calc_res = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
      end else begin
        calc_res = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
      end
    end
`endif
  end

  // next state and datapath registers; flush wins over any handshake in the same cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tag_d       = tag_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i && alive_q) begin
          op_d   = in_op;
          tag_d  = bus.tag_i;
          cnt_d  = '0;
          acc_d  = {{XLEN{1'b0}}, (in_is_div ? mag1 : mag2)};
          opnd_d = in_is_div ? mag2 : mag1;
          neg_d  = (in_is_div && in_op[1]) ? neg1 : (neg1 ^ neg2);
          if (special) begin
            // valid is raised one cycle later in DONE so the latency is one edge
            result_d    = special_res;
            out_valid_d = 1'b0;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d    = calc_res;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    if (bus.flush_i) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end
  end

  // state register; alive_q keeps in_ready low through reset without a path from rst_n
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      alive_q     <= 1'b1;
    end
  end

  assign bus.in_ready_o  = alive_q && (state_q == ST_IDLE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;
  assign bus.tag_o       = tag_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv (expectations follow EX_MULDIV_DIV_EN)
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ex_muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

  ex_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg);
    int n;
    n = 0;
    bus.op_i       = op;
    bus.src1_i     = a;
    bus.src2_i     = b;
    bus.tag_i      = tg;
    bus.in_valid_i = 1'b1;
    while (!bus.in_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("issue_ready", {31'd0, bus.in_ready_o}, 32'd1);
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid_o && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] tg,
                     input logic [31:0] exp_res, input int exp_lat);
    int lat;
    issue(op, a, b, tg);
    wait_valid(lat);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, bus.result_o, exp_res);
    chk({name, "_tag"}, {27'd0, bus.tag_o}, {27'd0, tg});
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk({name, "_rdy_after"}, {31'd0, bus.in_ready_o}, 32'd1);
  endtask

  task automatic watch_no_valid(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid_o) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    int          lat;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.op_i        = 3'b000;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.tag_i       = '0;
    bus.out_ready_i = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_tag", {27'd0, bus.tag_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, bus.in_ready_o}, 32'd1);

    // multiply variants
    run("mul",    MULDIV_MUL_OP,    32'd7,          32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 32);
    run("mulh",   MULDIV_MULH_OP,   32'h80000000,   32'h80000000, 5'd1, 32'h40000000, 32);
    run("mulhu",  MULDIV_MULHU_OP,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 32);
    run("mulhsu", MULDIV_MULHSU_OP, 32'hFFFFFFFF,   32'd2,        5'd4, 32'hFFFFFFFF, 32);

    // divide variants
    run("div",  MULDIV_DIV_OP,  32'hFFFFFFF9, 32'd2, 5'd5, DIV_ON ? 32'hFFFFFFFD : 32'd0, DIV_ON ? 32 : 1);
    run("rem",  MULDIV_REM_OP,  32'hFFFFFFF9, 32'd2, 5'd6, DIV_ON ? 32'hFFFFFFFF : 32'd0, DIV_ON ? 32 : 1);
    run("divu", MULDIV_DIVU_OP, 32'd100,      32'd7, 5'd7, DIV_ON ? 32'd14 : 32'd0,        DIV_ON ? 32 : 1);
    run("remu", MULDIV_REMU_OP, 32'd100,      32'd7, 5'd8, DIV_ON ? 32'd2 : 32'd0,         DIV_ON ? 32 : 1);

    // special cases
    run("divu0",  MULDIV_DIVU_OP, 32'd5,        32'd0,        5'd9,  DIV_ON ? 32'hFFFFFFFF : 32'd0, 1);
    run("rem0",   MULDIV_REM_OP,  32'd5,        32'd0,        5'd10, DIV_ON ? 32'd5 : 32'd0,        1);
    run("divovf", MULDIV_DIV_OP,  32'h80000000, 32'hFFFFFFFF, 5'd12, DIV_ON ? 32'h80000000 : 32'd0, 1);
    run("removf", MULDIV_REM_OP,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,                          1);

    // backpressure
    issue(MULDIV_MULHU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
    wait_valid(lat);
    chk("bp_lat", lat, 32);
    held_res = bus.result_o;
    held_tag = bus.tag_o;
    chk("bp_res", held_res, 32'hFFFFFFFE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_res", bus.result_o, 32'hFFFFFFFE);
      chk("bp_hold_tag", {27'd0, bus.tag_o}, 32'd21);
      chk("bp_hold_valid", {31'd0, bus.out_valid_o}, 32'd1);
      chk("bp_hold_rdy", {31'd0, bus.in_ready_o}, 32'd0);
    end
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.op_i        = MULDIV_MUL_OP;
    bus.src1_i      = 32'd3;
    bus.src2_i      = 32'd4;
    bus.tag_i       = 5'd22;
    tick();
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    chk("bp_post_rdy", {31'd0, bus.in_ready_o}, 32'd1);
    chk("bp_post_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("bp_post_valid", {31'd0, bus.out_valid_o}, 32'd0);

    // abort with flush at iteration 10
    issue(MULDIV_MUL_OP, 32'h00012345, 32'h00006789, 5'd17);
    repeat (10) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("fl_rdy", {31'd0, bus.in_ready_o}, 32'd1);
    watch_no_valid("fl_no_valid");
    run("fl_next", MULDIV_MUL_OP, 32'd3, 32'd4, 5'd11, 32'd12, 32);

    // abort with reset at iteration 10
    issue(MULDIV_MUL_OP, 32'h00012345, 32'h00006789, 5'd18);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("ra_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("ra_rdy_low", {31'd0, bus.in_ready_o}, 32'd0);
    chk("ra_valid", {31'd0, bus.out_valid_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ra_rdy", {31'd0, bus.in_ready_o}, 32'd1);
    watch_no_valid("ra_no_valid");
    run("ra_next", MULDIV_MUL_OP, 32'd3, 32'd4, 5'd13, 32'd12, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit, parametrised in operand width. It sits beside the single-cycle EX ALU and accepts M-extension operations from ID/EX over a valid/ready handshake. It computes one radix-2 step per cycle and returns the result with its destination tag to EX/MEM, holding it until that stage accepts it. While it is busy, ID/EX stalls on `in_ready_o`.

## Interface
- `XLEN`, 32: operand and result width; must be even and at least 8.
- `TAG_W`, 5: width of the pass-through destination tag (rd address).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  abort any operation in flight (branch mispredict or trap).
- `in_valid_i`  in  1  an operation is presented.
- `in_ready_o`  out  1  the unit can accept an operation.
- `op_i`  in  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, encoded 000 to 111 in that order.
- `src1_i`, `src2_i`  in  XLEN  rs1 and rs2 operands.
- `tag_i`  in  TAG_W  destination register address.
- `out_valid_o`  out  1  a result is held.
- `out_ready_i`  in  1  EX/MEM accepts the result.
- `result_o`  out  XLEN  the result.
- `tag_o`  out  TAG_W  the tag captured with the operation.
- `busy_o`  out  1  the unit is in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready_o` is 1. On `in_valid_i`, latch op, tag, operand magnitudes and sign flags. A special case goes to DONE; any other operation goes to CALC with the count at 0.
  - CALC: one iteration per cycle while the count runs 0 to XLEN-1. On the last iteration, apply the sign fix-up, write `result_o` and go to DONE.
  - DONE: `out_valid_o` is 1 and `result_o`/`tag_o` are held stable. When `out_ready_i` is 1, go to IDLE.
- Multiply:
  - Shift-add over the operand magnitudes into a 2*XLEN product.
  - Signedness: MULH treats both operands as signed, MULHSU treats src1 as signed and src2 as unsigned, MULHU and MUL treat both as unsigned.
  - Negate the product if the operand signs differ.
  - MUL selects the low XLEN bits; the MULH variants select the high XLEN bits.
- Divide: restoring algorithm over the magnitudes.
  - For DIV, the quotient is negated if the operand signs differ.
  - For REM, the remainder takes the sign of the dividend.
- Special cases complete without entering CALC:
  - Divide by zero: quotient is all-ones; remainder is src1.
  - Signed overflow (DIV/REM of the most-negative value by -1): quotient is the most-negative value; remainder is 0.
- Flush: `flush_i` forces IDLE at the next edge from any state and drops any held result. It overrides a simultaneous accept or output handshake.
- Reset (while `rst_n` is 0 at an edge):
  - State is IDLE.
  - `out_valid_o`, `result_o`, `tag_o` and `busy_o` are 0.
  - `in_ready_o` is 0 while `rst_n` is low and 1 from the first cycle after release.
  - Reset mid-operation discards the operation silently.

## Timing
- Accept occurs at an edge where `in_valid_i` and `in_ready_o` are both 1 (edge k).
- Normal operation: `out_valid_o` rises after edge k+XLEN, giving XLEN cycles of latency.
- Special cases: `out_valid_o` rises after edge k+1.
- At most one operation is in flight. There is no accept in the same cycle as an output handshake; `in_ready_o` returns to 1 the cycle after the handshake.
- `in_ready_o` is a function of the state register only, with no combinational path from any input. `out_valid_o`, `result_o` and `tag_o` are registered.

## Configuration
- `EX_MULDIV_DIV_EN`:
  - Defined: the divider datapath and its special cases are built.
  - Undefined: only the multiplier is built. DIV, DIVU, REM and REMU complete as one-cycle special cases with `result_o` = 0, so the decoder must not issue them.

## Structure
- The shared header holds the funct3 op codes (`MULDIV_*_OP`), the FSM state encodings and the default `XLEN`/`TAG_W` values.
- The FSM, count, operand latches and sign fix-up live in `ex_muldiv`.
- Sub-module `muldiv_step` holds the combinational single-iteration datapath: one shift-add or one restoring subtract on the 2*XLEN accumulator, selected by a mul/div flag.

## Test plan
- MUL 7 × 0xFFFFFFFD, tag 3: `result_o` = 0xFFFFFFEB, `tag_o` = 3, `out_valid_o` rises exactly 32 cycles after accept.
- MULH 0x80000000 × 0x80000000 gives 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 gives 0xFFFFFFFD. REM on the same operands gives 0xFFFFFFFF. DIVU 100 / 7 gives 14. REMU 100 / 7 gives 2.
- Special cases, each valid one cycle after accept:
  - DIVU 5 / 0 gives 0xFFFFFFFF; REM 5 / 0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM on the same operands gives 0.
- Backpressure: hold `out_ready_i` at 0 for 5 cycles after `out_valid_o` rises.
  - `result_o` and `tag_o` stay stable and `in_ready_o` stays 0.
  - The handshake is followed by `in_ready_o` = 1 on the next cycle.
  - A new `in_valid_i` presented in the handshake cycle is not accepted.
- Abort at iteration 10, run once with `flush_i` and once with `rst_n` low:
  - `out_valid_o` never asserts for that operation; `in_ready_o` returns to 1.
  - A following MUL 3 × 4 returns 12 with its own tag.
